// File: rtl/loop_nest_ctrl.sv
// Three-level nested loop sequencer: emits (IDX0, IDX1, IDX2) tuples, inner index fastest,
// under a START/STALL/ABORT handshake with programmable inclusive upper bounds.
module loop_nest_ctrl #(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   CFG_WR_EN,
  input  logic [1:0]             CFG_LOOP_ID,
  input  logic [COUNT_WIDTH-1:0] CFG_MAX,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic                   STALL,
  output logic                   BUSY,
  output logic                   VALID,
  output logic [COUNT_WIDTH-1:0] IDX0,
  output logic [COUNT_WIDTH-1:0] IDX1,
  output logic [COUNT_WIDTH-1:0] IDX2,
  output logic                   LAST0,
  output logic                   LAST1,
  output logic                   LAST2,
  output logic                   DONE
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state;
  logic [COUNT_WIDTH-1:0] max0, max1, max2;
  logic                   at_max0, at_max1, at_max2;

  assign at_max0 = (IDX0 == max0);
  assign at_max1 = (IDX1 == max1);
  assign at_max2 = (IDX2 == max2);

  assign LAST0 = VALID && at_max0;
  assign LAST1 = VALID && at_max1;
  assign LAST2 = VALID && at_max2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= StIdle;
      max0  <= '0;
      max1  <= '0;
      max2  <= '0;
      IDX0  <= '0;
      IDX1  <= '0;
      IDX2  <= '0;
      BUSY  <= 1'b0;
      VALID <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          DONE <= 1'b0;
          // The bound write and START share an edge, so the run sees the new bound.
          if (CFG_WR_EN) begin
            case (CFG_LOOP_ID)
              2'd0:    max0 <= CFG_MAX;
              2'd1:    max1 <= CFG_MAX;
              2'd2:    max2 <= CFG_MAX;
              default: ;
            endcase
          end
          if (START) begin
            state <= StRun;
            BUSY  <= 1'b1;
            VALID <= 1'b1;
            IDX0  <= '0;
            IDX1  <= '0;
            IDX2  <= '0;
          end
        end

        StRun: begin
          if (ABORT) begin
            state <= StIdle;
            BUSY  <= 1'b0;
            VALID <= 1'b0;
            IDX0  <= '0;
            IDX1  <= '0;
            IDX2  <= '0;
          end else if (!STALL) begin
            if (at_max0 && at_max1 && at_max2) begin
              state <= StDone;
              VALID <= 1'b0;
              DONE  <= 1'b1;
              IDX0  <= '0;
              IDX1  <= '0;
              IDX2  <= '0;
            end else if (!at_max0) begin
              IDX0 <= IDX0 + COUNT_WIDTH'(1);
            end else begin
              IDX0 <= '0;
              if (!at_max1) begin
                IDX1 <= IDX1 + COUNT_WIDTH'(1);
              end else begin
                IDX1 <= '0;
                IDX2 <= IDX2 + COUNT_WIDTH'(1);
              end
            end
          end
        end

        StDone: begin
          state <= StIdle;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end

        default: begin
          state <= StIdle;
          BUSY  <= 1'b0;
          VALID <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Bench for loop_nest_ctrl: expected tuple stream is built with nested for-loops and
// consumed on every accepted beat; directed scenarios plus randomized bounds and stalls.
module tb_loop_nest_ctrl;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RESET, CFG_WR_EN, START, ABORT, STALL;
  logic [1:0]   CFG_LOOP_ID;
  logic [W-1:0] CFG_MAX;
  logic         BUSY, VALID, LAST0, LAST1, LAST2, DONE;
  logic [W-1:0] IDX0, IDX1, IDX2;

  int tests  = 0;
  int failed = 0;

  loop_nest_ctrl #(.COUNT_WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .CFG_WR_EN(CFG_WR_EN), .CFG_LOOP_ID(CFG_LOOP_ID),
    .CFG_MAX(CFG_MAX), .START(START), .ABORT(ABORT), .STALL(STALL), .BUSY(BUSY),
    .VALID(VALID), .IDX0(IDX0), .IDX1(IDX1), .IDX2(IDX2), .LAST0(LAST0), .LAST1(LAST1),
    .LAST2(LAST2), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(BUSY), 0);
    chk({tag, ".valid"}, 32'(VALID), 0);
    chk({tag, ".done"}, 32'(DONE), 0);
    chk({tag, ".idx"}, {8'd0, IDX2, IDX1, IDX0}, 0);
    chk({tag, ".last"}, {29'd0, LAST2, LAST1, LAST0}, 0);
  endtask

  task automatic cfg(input int id, input int mx);
    CFG_WR_EN = 1'b1; CFG_LOOP_ID = 2'(id); CFG_MAX = W'(mx);
    step();
    CFG_WR_EN = 1'b0;
  endtask

  // Negative *_at values disable the corresponding event; beat counts accepted tuples.
  task automatic run(input string tag, input int m0, input int m1, input int m2,
                     input bit prog, input int stall_at, input int stall_pct,
                     input int inject_at, input int abort_at, input int reset_at);
    int q[$];
    int beat = 0, hold = 0, run_stall = 0, e, e0, e1, e2;
    bit stl;
    if (prog) begin
      cfg(0, m0); cfg(1, m1); cfg(2, m2);
    end
    for (int i2 = 0; i2 <= m2; i2++)
      for (int i1 = 0; i1 <= m1; i1++)
        for (int i0 = 0; i0 <= m0; i0++)
          q.push_back(i0 | (i1 << 8) | (i2 << 16));
    START = 1'b1;
    step();
    START = 1'b0;
    while (q.size() > 0) begin
      e = q[0]; e0 = e & 255; e1 = (e >> 8) & 255; e2 = (e >> 16) & 255;
      chk({tag, ".valid"}, 32'(VALID), 1);
      chk({tag, ".busy"}, 32'(BUSY), 1);
      chk({tag, ".done"}, 32'(DONE), 0);
      chk({tag, ".idx"}, {8'd0, IDX2, IDX1, IDX0}, 32'(e));
      chk({tag, ".last"}, {29'd0, LAST2, LAST1, LAST0},
          {29'd0, e2 == m2, e1 == m1, e0 == m0});
      if (beat == abort_at) begin
        ABORT = 1'b1; step(); ABORT = 1'b0;
        chk_idle({tag, ".abort"});
        step();
        chk_idle({tag, ".abort2"});
        return;
      end
      if (beat == reset_at) begin
        RESET = 1'b1; step(); RESET = 1'b0;
        chk_idle({tag, ".reset"});
        return;
      end
      if (beat == inject_at) begin
        CFG_WR_EN = 1'b1; CFG_LOOP_ID = 2'd0; CFG_MAX = W'(5); START = 1'b1;
      end
      stl = 1'b0;
      if (beat == stall_at && hold < 3) begin
        stl = 1'b1; hold++;
      end else if (stall_pct > 0 && run_stall < 4 && $urandom_range(99) < stall_pct) begin
        stl = 1'b1;
      end
      run_stall = stl ? run_stall + 1 : 0;
      STALL = stl;
      step();
      STALL = 1'b0; CFG_WR_EN = 1'b0; START = 1'b0;
      if (!stl) begin
        void'(q.pop_front());
        beat++;
      end
    end
    chk({tag, ".fin_done"}, 32'(DONE), 1);
    chk({tag, ".fin_busy"}, 32'(BUSY), 1);
    chk({tag, ".fin_valid"}, 32'(VALID), 0);
    chk({tag, ".fin_idx"}, {8'd0, IDX2, IDX1, IDX0}, 0);
    // START during the done cycle must not launch a run.
    START = 1'b1;
    step();
    START = 1'b0;
    chk_idle({tag, ".post"});
  endtask

  initial begin
    RESET = 1'b1; CFG_WR_EN = 1'b0; CFG_LOOP_ID = 2'd0; CFG_MAX = '0;
    START = 1'b0; ABORT = 1'b0; STALL = 1'b0;
    step(); step();
    chk_idle("reset");
    RESET = 1'b0;
    ABORT = 1'b1; step(); ABORT = 1'b0;
    chk_idle("idle_abort");

    run("basic", 2, 1, 1, 1'b1, -1, 0, -1, -1, -1);
    run("stall", 2, 1, 1, 1'b0, 2, 0, -1, -1, -1);
    run("zero", 0, 0, 0, 1'b1, -1, 0, -1, -1, -1);
    run("inject", 2, 1, 1, 1'b1, -1, 0, 3, -1, -1);
    run("inject_rerun", 2, 1, 1, 1'b0, -1, 0, -1, -1, -1);
    run("abort", 2, 1, 1, 1'b0, -1, 0, -1, 4, -1);
    run("abort_rerun", 2, 1, 1, 1'b0, -1, 0, -1, -1, -1);
    run("reset_mid", 2, 1, 1, 1'b0, -1, 0, -1, -1, 7);
    run("after_reset", 0, 0, 0, 1'b0, -1, 0, -1, -1, -1);
    run("wide", 255, 0, 0, 1'b1, -1, 0, -1, -1, -1);

    // Same-cycle write and START: the run must use the freshly written bound.
    cfg(1, 0); cfg(2, 0);
    CFG_WR_EN = 1'b1; CFG_LOOP_ID = 2'd0; CFG_MAX = W'(3);
    run("wr_start", 3, 0, 0, 1'b0, -1, 0, -1, -1, -1);

    for (int r = 0; r < 8; r++)
      run("rand", int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
          1'b1, -1, 30, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
